// File: rtl/ram_loader_if.sv
// Byte-stream-in / RAM-write-out bus of the RAM image loader.
// master = loader side, slave = receiver/RAM/control side.
interface ram_loader_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int WIDTH      = 16
);
  logic [7:0]            i_rx_data;
  logic                  i_rx_valid;
  logic [ADDR_WIDTH-1:0] o_address;
  logic                  o_load_enable;
  logic [WIDTH-1:0]      o_load_data;
  logic                  o_busy;
  logic                  o_done;
  logic                  o_error;

  modport master (
    input  i_rx_data, i_rx_valid,
    output o_address, o_load_enable, o_load_data, o_busy, o_done, o_error
  );
  modport slave (
    output i_rx_data, i_rx_valid,
    input  o_address, o_load_enable, o_load_data, o_busy, o_done, o_error
  );
endinterface

// File: rtl/ram_loader.sv
// Decodes a framed byte stream (sync, addr, count, words, xor checksum) and
// writes the words into the single-port RAM in place of the CPU.
module ram_loader #(
  parameter int         RAM_DEPTH = 2**16,
  parameter int         WIDTH     = 16,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input logic clk,
  input logic rst,
  input logic clk_en,
  ram_loader_if.master bus
);
  localparam int ADDR_WIDTH     = $clog2(RAM_DEPTH);
  localparam int BYTES_PER_WORD = WIDTH / 8;
  localparam int BCW            = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  typedef enum logic [2:0] {IDLE, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, DATA, CSUM} state_t;

  state_t                state;
  logic [7:0]            addr_hi, cnt_hi, csum;
  logic [15:0]           words_left;
  logic [BCW-1:0]        byte_cnt;
  logic [ADDR_WIDTH-1:0] address;
  logic [WIDTH-1:0]      load_data;
  logic                  load_enable, busy, done, error;

  logic [7:0] rx;
  assign rx = bus.i_rx_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      addr_hi     <= '0;
      cnt_hi      <= '0;
      csum        <= '0;
      words_left  <= '0;
      byte_cnt    <= '0;
      address     <= '0;
      load_data   <= '0;
      load_enable <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (bus.i_rx_valid && load_enable) begin
        // A byte arriving while a word still waits for its commit is lost.
        load_enable <= 1'b0;
        error       <= 1'b1;
        busy        <= 1'b0;
        state       <= IDLE;
      end else begin
        if (load_enable && clk_en) begin
          load_enable <= 1'b0;
          address     <= (address == ADDR_WIDTH'(RAM_DEPTH - 1)) ? '0
                                                                 : address + ADDR_WIDTH'(1);
        end
        if (bus.i_rx_valid) begin
          unique case (state)
            IDLE: if (rx == SYNC_BYTE) begin
              state <= ADDR_HI;
              busy  <= 1'b1;
              error <= 1'b0;
              csum  <= '0;
            end
            ADDR_HI: begin
              addr_hi <= rx;
              csum    <= csum ^ rx;
              state   <= ADDR_LO;
            end
            ADDR_LO: begin
              address <= ADDR_WIDTH'({addr_hi, rx});
              csum    <= csum ^ rx;
              state   <= CNT_HI;
            end
            CNT_HI: begin
              cnt_hi <= rx;
              csum   <= csum ^ rx;
              state  <= CNT_LO;
            end
            CNT_LO: begin
              words_left <= {cnt_hi, rx};
              byte_cnt   <= '0;
              csum       <= csum ^ rx;
              state      <= ({cnt_hi, rx} == 16'd0) ? CSUM : DATA;
            end
            DATA: begin
              load_data <= WIDTH'({load_data, rx});
              csum      <= csum ^ rx;
              if (byte_cnt == BCW'(BYTES_PER_WORD - 1)) begin
                byte_cnt    <= '0;
                load_enable <= 1'b1;
                words_left  <= words_left - 16'd1;
                if (words_left == 16'd1) state <= CSUM;
              end else begin
                byte_cnt <= byte_cnt + BCW'(1);
              end
            end
            CSUM: begin
              state <= IDLE;
              busy  <= 1'b0;
              if (rx == csum) done  <= 1'b1;
              else            error <= 1'b1;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

  assign bus.o_address     = address;
  assign bus.o_load_enable = load_enable;
  assign bus.o_load_data   = load_data;
  assign bus.o_busy        = busy;
  assign bus.o_done        = done;
  assign bus.o_error       = error;
endmodule

// File: tb/tb_ram_loader.sv
// Scoreboard bench: stimulus pushes expected RAM writes and frame results,
// negedge monitors pop them as the loaders commit writes or report results.
module tb_ram_loader;
  logic clk = 1'b0, rst = 1'b1, clk_en = 1'b1;
  always #5 clk = ~clk;

  ram_loader_if #(.ADDR_WIDTH(16), .WIDTH(16)) bus ();
  ram_loader_if #(.ADDR_WIDTH(4),  .WIDTH(16)) bus16 ();

  ram_loader dut (.clk(clk), .rst(rst), .clk_en(clk_en), .bus(bus));
  ram_loader #(.RAM_DEPTH(16)) dut16 (.clk(clk), .rst(rst), .clk_en(clk_en), .bus(bus16));

  typedef struct { logic [31:0] addr; logic [15:0] data; } wr_t;
  wr_t  exp_w[$], exp_w16[$];
  bit   exp_r[$], exp_r16[$];   // 1 = done pulse, 0 = error rise
  wr_t  we, we16;
  bit   r, r16;
  logic prev_err = 1'b0, prev_err16 = 1'b0;
  logic [7:0] fr[$];
  int n_checks = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic exp_write(input bit which, input logic [31:0] a, input logic [15:0] d);
    wr_t w;
    w.addr = a; w.data = d;
    if (which) exp_w16.push_back(w); else exp_w.push_back(w);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit which);
    @(posedge clk); #1;
    if (which) begin bus16.i_rx_data = b; bus16.i_rx_valid = 1'b1; end
    else       begin bus.i_rx_data   = b; bus.i_rx_valid   = 1'b1; end
    @(posedge clk); #1;
    bus.i_rx_valid = 1'b0; bus16.i_rx_valid = 1'b0;
  endtask

  task automatic send_q(input logic [7:0] q[$], input bit which);
    foreach (q[i]) send_byte(q[i], which);
  endtask

  // Main loader monitor: RAM commits and frame results.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_load_enable && clk_en) begin
        if (exp_w.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL wr_unexpected: got write %h@%h expected none", bus.o_load_data, bus.o_address);
        end else begin
          we = exp_w.pop_front();
          chk("wr_addr", 32'(bus.o_address), we.addr);
          chk("wr_data", 32'(bus.o_load_data), 32'(we.data));
        end
      end
      if (bus.o_done || (bus.o_error && !prev_err)) begin
        if (exp_r.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL result_unexpected: got done=%b error=%b expected none", bus.o_done, bus.o_error);
        end else begin
          r = exp_r.pop_front();
          chk("result_done", 32'(bus.o_done), 32'(r));
          chk("busy_at_result", 32'(bus.o_busy), 32'd0);
        end
      end
    end
    prev_err = bus.o_error;
  end

  // Small-RAM loader monitor.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus16.o_load_enable && clk_en) begin
        if (exp_w16.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL wr16_unexpected: got write %h@%h expected none", bus16.o_load_data, bus16.o_address);
        end else begin
          we16 = exp_w16.pop_front();
          chk("wr16_addr", 32'(bus16.o_address), we16.addr);
          chk("wr16_data", 32'(bus16.o_load_data), 32'(we16.data));
        end
      end
      if (bus16.o_done || (bus16.o_error && !prev_err16)) begin
        if (exp_r16.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL result16_unexpected: got done=%b error=%b expected none", bus16.o_done, bus16.o_error);
        end else begin
          r16 = exp_r16.pop_front();
          chk("result16_done", 32'(bus16.o_done), 32'(r16));
        end
      end
    end
    prev_err16 = bus16.o_error;
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_addr"},  32'(bus.o_address), 32'd0);
    chk({tag, "_le"},    32'(bus.o_load_enable), 32'd0);
    chk({tag, "_data"},  32'(bus.o_load_data), 32'd0);
    chk({tag, "_busy"},  32'(bus.o_busy), 32'd0);
    chk({tag, "_done"},  32'(bus.o_done), 32'd0);
    chk({tag, "_error"}, 32'(bus.o_error), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_rx_data = '0; bus.i_rx_valid = 1'b0;
    bus16.i_rx_data = '0; bus16.i_rx_valid = 1'b0;
    #2 chk_reset_outputs("rst0");
    chk("rst0_addr16", 32'(bus16.o_address), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Basic write, checksum 0x52
    exp_write(0, 32'h10, 16'h1234); exp_write(0, 32'h11, 16'hABCD); exp_r.push_back(1'b1);
    fr = {8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h52};
    send_q(fr, 0);
    chk("basic_busy", 32'(bus.o_busy), 32'd0);
    chk("basic_error", 32'(bus.o_error), 32'd0);
    chk("basic_addr", 32'(bus.o_address), 32'h12);

    // clk_en stall for 5 clk after the word's last byte, checksum 0x70
    exp_write(0, 32'h20, 16'hBEEF); exp_r.push_back(1'b1);
    fr = {8'hA5, 8'h00, 8'h20, 8'h00, 8'h01, 8'hBE};
    send_q(fr, 0);
    clk_en = 1'b0;
    send_byte(8'hEF, 0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_le", 32'(bus.o_load_enable), 32'd1);
      chk("stall_addr", 32'(bus.o_address), 32'h20);
      @(posedge clk); #1;
    end
    clk_en = 1'b1;
    chk("stall_le_pre", 32'(bus.o_load_enable), 32'd1);
    @(posedge clk); #1;
    chk("stall_le_post", 32'(bus.o_load_enable), 32'd0);
    chk("stall_addr_post", 32'(bus.o_address), 32'h21);
    send_byte(8'h70, 0);
    chk("stall_addr_end", 32'(bus.o_address), 32'h21);
    chk("stall_busy", 32'(bus.o_busy), 32'd0);

    // Address wrap on the 16-word loader, checksum 0x0D
    exp_write(1, 32'd15, 16'h1111); exp_write(1, 32'd0, 16'h2222); exp_r16.push_back(1'b1);
    fr = {8'hA5, 8'h00, 8'h0F, 8'h00, 8'h02, 8'h11, 8'h11, 8'h22, 8'h22, 8'h0D};
    send_q(fr, 1);
    chk("wrap_addr", 32'(bus16.o_address), 32'd1);
    chk("wrap_busy", 32'(bus16.o_busy), 32'd0);

    // Bad checksum: words still written, error set
    exp_write(0, 32'h10, 16'h1234); exp_write(0, 32'h11, 16'hABCD); exp_r.push_back(1'b0);
    fr = {8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h53};
    send_q(fr, 0);
    chk("bad_error", 32'(bus.o_error), 32'd1);
    chk("bad_busy", 32'(bus.o_busy), 32'd0);

    // Junk ignored, then CNT=0 frame; sync clears the error
    fr = {8'h00, 8'hFF};
    send_q(fr, 0);
    chk("junk_busy", 32'(bus.o_busy), 32'd0);
    chk("junk_error", 32'(bus.o_error), 32'd1);
    send_byte(8'hA5, 0);
    chk("sync_error_clr", 32'(bus.o_error), 32'd0);
    chk("sync_busy", 32'(bus.o_busy), 32'd1);
    exp_r.push_back(1'b1);
    fr = {8'h12, 8'h34, 8'h00, 8'h00, 8'h26};
    send_q(fr, 0);
    chk("cnt0_addr", 32'(bus.o_address), 32'h1234);
    chk("cnt0_busy", 32'(bus.o_busy), 32'd0);
    chk("cnt0_error", 32'(bus.o_error), 32'd0);

    // Overrun: byte arrives while a word is still uncommitted
    exp_r.push_back(1'b0);
    fr = {8'hA5, 8'h00, 8'h60, 8'h00, 8'h02, 8'h11};
    send_q(fr, 0);
    clk_en = 1'b0;
    send_byte(8'h22, 0);
    chk("ovr_le_pending", 32'(bus.o_load_enable), 32'd1);
    send_byte(8'h33, 0);
    chk("ovr_le", 32'(bus.o_load_enable), 32'd0);
    chk("ovr_error", 32'(bus.o_error), 32'd1);
    chk("ovr_busy", 32'(bus.o_busy), 32'd0);
    chk("ovr_addr", 32'(bus.o_address), 32'h60);
    clk_en = 1'b1;

    // Async reset after one data byte, then a clean frame (checksum 0x65)
    fr = {8'hA5, 8'h00, 8'h40, 8'h00, 8'h01, 8'hAA};
    send_q(fr, 0);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("rst_mid");
    @(posedge clk); #1 rst = 1'b0;
    exp_write(0, 32'h50, 16'hCAFE); exp_r.push_back(1'b1);
    fr = {8'hA5, 8'h00, 8'h50, 8'h00, 8'h01, 8'hCA, 8'hFE, 8'h65};
    send_q(fr, 0);
    chk("post_rst_addr", 32'(bus.o_address), 32'h51);

    repeat (3) @(posedge clk);
    #1;
    chk("left_writes", 32'(exp_w.size()), 32'd0);
    chk("left_writes16", 32'(exp_w16.size()), 32'd0);
    chk("left_results", 32'(exp_r.size()), 32'd0);
    chk("left_results16", 32'(exp_r16.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
